hazard_forward_ctrl: RTL

//  Pipeline hazard controller for the 5-stage RV32 core.
//  - Drives the 2-bit selects of the two EX-stage operand forwarding 3:1 muxes:
//    00 = register-file value, 01 = WB-stage result, 10 = MEM-stage ALU result.
//  - Generates the load-use stall, the branch flush and the data-memory wait freeze.
//  - Keeps saturating stall/flush performance counters and a data-memory timeout fault flag.

---
 rtl/hazard_forward_ctrl_if.sv | 19 +
 rtl/hazard_forward_ctrl.sv | 86 ++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl_if.sv
// hazard_forward_ctrl_if: pipeline-side signals of the hazard/forwarding controller
interface hazard_forward_ctrl_if #(parameter int CNT_W = 32);
   logic [4:0]       id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic             id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
   logic             mem_reg_write, wb_reg_write, dmem_req, dmem_ready;
   logic [1:0]       fwd_a_sel, fwd_b_sel;
   logic             stall_if, bubble_ex, flush_id, freeze, fault;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd, ex_mem_read,
             ex_branch_taken, mem_rd, mem_reg_write, wb_rd, wb_reg_write, dmem_req, dmem_ready,
      input  fwd_a_sel, fwd_b_sel, stall_if, bubble_ex, flush_id, freeze, fault, stall_cnt, flush_cnt
   );
   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd, ex_mem_read,
             ex_branch_taken, mem_rd, mem_reg_write, wb_rd, wb_reg_write, dmem_req, dmem_ready,
      output fwd_a_sel, fwd_b_sel, stall_if, bubble_ex, flush_id, freeze, fault, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: EX operand forwarding selects, load-use stall, branch flush, dmem freeze and perf counters
module hazard_forward_ctrl #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 255
) (
   input logic                 clk,
   input logic                 rst,
   hazard_forward_ctrl_if.slave bus
);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] TMO = WW'(TIMEOUT);
   typedef enum logic [1:0] {RUN, WAIT, FAULT} state_t;
   state_t           r_state, w_next;
   logic [WW-1:0]    r_wait_cnt, w_wait_nxt;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
   logic             w_load_use, w_decode, w_freeze, w_stall, w_bubble, w_flush;
   logic [1:0]       w_fwd_a, w_fwd_b;
   // forwarding selects: MEM beats WB, x0 never forwarded
   always_comb begin
      w_fwd_a = (bus.mem_reg_write && bus.mem_rd != 5'd0 && bus.mem_rd == bus.ex_rs1) ? 2'b10 :
                (bus.wb_reg_write && bus.wb_rd != 5'd0 && bus.wb_rd == bus.ex_rs1) ? 2'b01 : 2'b00;
      w_fwd_b = (bus.mem_reg_write && bus.mem_rd != 5'd0 && bus.mem_rd == bus.ex_rs2) ? 2'b10 :
                (bus.wb_reg_write && bus.wb_rd != 5'd0 && bus.wb_rd == bus.ex_rs2) ? 2'b01 : 2'b00;
      w_load_use = bus.ex_mem_read && bus.ex_rd != 5'd0 &&
                   ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) || (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
   end
   // dmem wait FSM: next state, freeze, and whether branch/load-use decode is live this cycle
   always_comb begin
      w_next     = r_state;
      w_wait_nxt = r_wait_cnt;
      w_freeze   = 1'b0;
      w_decode   = 1'b0;
      case (r_state)
         RUN: begin
            if (bus.dmem_req && !bus.dmem_ready) begin
               w_freeze   = 1'b1;
               w_next     = WAIT;
               w_wait_nxt = WW'(1);
            end else begin
               w_decode = 1'b1;
            end
         end
         WAIT: begin
            w_wait_nxt = r_wait_cnt + WW'(1);
            if (bus.dmem_ready) begin
               w_next   = RUN;
               w_decode = 1'b1;
            end else begin
               w_freeze = 1'b1;
               if (r_wait_cnt == TMO) w_next = FAULT;
            end
         end
         FAULT: w_freeze = 1'b1;
         default: w_next = RUN;
      endcase
      w_flush  = w_decode && bus.ex_branch_taken;
      w_stall  = w_decode && !bus.ex_branch_taken && w_load_use;
      w_bubble = w_decode && (bus.ex_branch_taken || w_load_use);
   end
   // state, wait counter and saturating performance counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= RUN;
         r_wait_cnt  <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state    <= w_next;
         r_wait_cnt <= w_wait_nxt;
         if ((w_stall || w_freeze) && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end
   // outputs are forced quiet while reset is held
   always_comb begin
      bus.fwd_a_sel = rst ? 2'b00 : w_fwd_a;
      bus.fwd_b_sel = rst ? 2'b00 : w_fwd_b;
      bus.stall_if  = !rst && w_stall;
      bus.bubble_ex = !rst && w_bubble;
      bus.flush_id  = !rst && w_flush;
      bus.freeze    = !rst && w_freeze;
      bus.fault     = r_state == FAULT;
      bus.stall_cnt = r_stall_cnt;
      bus.flush_cnt = r_flush_cnt;
   end
endmodule
